// File: rtl/pkg_cpu.sv
// Shared CPU datapath types for the divider sequencer: FSM state encoding,
// the default watchdog length and the request/response bundle layouts.
package pkg_cpu;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } DivSeqState;

  // Widest divider unit in the datapath (divmod64); sizes the bundle structs.
  localparam int DIV_SEQ_MAX_WIDTH = 64;

  // Watchdog length: two cycles per quotient bit plus pipeline slack.
  function automatic int div_seq_default_timeout(input int width);
    return 2 * width + 8;
  endfunction

  typedef struct packed {
    logic                         unsgn_or_sgn;
    logic [DIV_SEQ_MAX_WIDTH-1:0] num;
    logic [DIV_SEQ_MAX_WIDTH-1:0] denom;
  } StrcInDivSeq;

  typedef struct packed {
    logic [DIV_SEQ_MAX_WIDTH-1:0] quot;
    logic [DIV_SEQ_MAX_WIDTH-1:0] rem;
    logic                         timeout;
    logic                         div_by_zero;
  } StrcOutDivSeq;

endpackage

// File: rtl/div_seq_watchdog.sv
// Saturating cycle counter for the divider sequencer's wait state.
// clr_i restarts the count (and wins over en_i); expired_o flags the last
// permitted cycle, i.e. count == TIMEOUT_CYCLES-1.
module div_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 72
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   SAT  = '1;

  logic [CW-1:0] count_q, count_d;

  // Next count: clear, hold, or step up without wrapping past all-ones.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, not in the sensitivity
    // list; state updates use non-blocking assignments only.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/divider_sequencer.sv
// Sequencing controller for one NonRestoringDivider instance.
// Takes one request over valid/ready, waits for the divider to accept a
// command, pulses div_enable for one cycle, waits for div_data_ready under a
// watchdog, then holds the response until the consumer takes it.
// Optional feature: define DIVIDER_SEQUENCER_ZERO_CHECK_EN to answer a zero
// divisor directly (quot all ones, rem = num, rsp_div_by_zero) without
// touching the divider.
module divider_sequencer
  import pkg_cpu::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = div_seq_default_timeout(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_unsgn_or_sgn,
  input  logic [WIDTH-1:0] req_num,
  input  logic [WIDTH-1:0] req_denom,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quot,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_timeout,
  output logic             rsp_div_by_zero,
  output logic             div_enable,
  output logic             div_unsgn_or_sgn,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_denom,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  input  logic             div_can_accept_cmd,
  input  logic             div_data_ready
);

  DivSeqState       state_q;
  logic             req_ready_q;
  logic             div_enable_q;
  logic             div_sgn_q;
  logic [WIDTH-1:0] div_num_q;
  logic [WIDTH-1:0] div_denom_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_quot_q;
  logic [WIDTH-1:0] rsp_rem_q;
  logic             rsp_timeout_q;
  logic             rsp_dbz_q;

  logic zero_bypass;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;

`ifdef DIVIDER_SEQUENCER_ZERO_CHECK_EN
  assign zero_bypass = (req_denom == '0);
`else
  // Without the zero check, rsp_dbz_q never sets and synthesises to a constant.
  assign zero_bypass = 1'b0;
`endif

  // Watchdog restarts on the issue edge and runs for every wait cycle.
  assign wd_clr = (state_q == StIssue) && div_can_accept_cmd;
  assign wd_en  = (state_q == StWait);

  div_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  // Request/issue/wait/respond FSM with operand and result latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b1;
      div_enable_q  <= 1'b0;
      div_sgn_q     <= 1'b0;
      div_num_q     <= '0;
      div_denom_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_quot_q    <= '0;
      rsp_rem_q     <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_dbz_q     <= 1'b0;
    end else begin
      div_enable_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            div_sgn_q   <= req_unsgn_or_sgn;
            div_num_q   <= req_num;
            div_denom_q <= req_denom;
            req_ready_q <= 1'b0;
            if (zero_bypass) begin
              state_q     <= StDone;
              rsp_valid_q <= 1'b1;
              rsp_quot_q  <= '1;
              rsp_rem_q   <= req_num;
              rsp_dbz_q   <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (div_can_accept_cmd) begin
            div_enable_q <= 1'b1;
            state_q      <= StWait;
          end
        end
        StWait: begin
          // div_enable_q is high only in the first wait cycle; a ready seen
          // then belongs to the previous operation.
          if (div_data_ready && !div_enable_q) begin
            rsp_quot_q  <= div_quot;
            rsp_rem_q   <= div_rem;
            rsp_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (wd_expired) begin
            rsp_quot_q    <= '0;
            rsp_rem_q     <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_dbz_q     <= 1'b0;
            req_ready_q   <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign div_enable       = div_enable_q;
  assign div_unsgn_or_sgn = div_sgn_q;
  assign div_num          = div_num_q;
  assign div_denom        = div_denom_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_quot         = rsp_quot_q;
  assign rsp_rem          = rsp_rem_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign rsp_div_by_zero  = rsp_dbz_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer: a 32-bit instance driven by a
// table of directed divides plus hand-written corner sequences, and a 64-bit
// instance exercising reset-in-wait and two divides.
module tb_divider_sequencer;

  localparam int TC32 = 72;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        req_valid, req_ready, req_sgn;
  logic [31:0] req_num, req_denom;
  logic        rsp_valid, rsp_ready, rsp_timeout, rsp_dbz;
  logic [31:0] rsp_quot, rsp_rem;
  logic        div_enable, div_sgn;
  logic [31:0] div_num, div_denom;
  logic [31:0] div_quot = '0, div_rem = '0;
  logic        div_can_accept_cmd;
  logic        div_data_ready = 1'b0;

  divider_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_unsgn_or_sgn(req_sgn),
    .req_num(req_num), .req_denom(req_denom),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
    .rsp_timeout(rsp_timeout), .rsp_div_by_zero(rsp_dbz),
    .div_enable(div_enable), .div_unsgn_or_sgn(div_sgn), .div_num(div_num), .div_denom(div_denom),
    .div_quot(div_quot), .div_rem(div_rem),
    .div_can_accept_cmd(div_can_accept_cmd), .div_data_ready(div_data_ready)
  );

  // ---------------- 64-bit instance ----------------
  logic        w_req_valid, w_req_ready, w_req_sgn;
  logic [63:0] w_req_num, w_req_denom;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_timeout, w_rsp_dbz;
  logic [63:0] w_rsp_quot, w_rsp_rem;
  logic        w_div_enable, w_div_sgn;
  logic [63:0] w_div_num, w_div_denom;
  logic [63:0] w_div_quot = '0, w_div_rem = '0;
  logic        w_div_data_ready = 1'b0;

  divider_sequencer #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_unsgn_or_sgn(w_req_sgn),
    .req_num(w_req_num), .req_denom(w_req_denom),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_quot(w_rsp_quot), .rsp_rem(w_rsp_rem),
    .rsp_timeout(w_rsp_timeout), .rsp_div_by_zero(w_rsp_dbz),
    .div_enable(w_div_enable), .div_unsgn_or_sgn(w_div_sgn), .div_num(w_div_num), .div_denom(w_div_denom),
    .div_quot(w_div_quot), .div_rem(w_div_rem),
    .div_can_accept_cmd(1'b1), .div_data_ready(w_div_data_ready)
  );

  // ---------------- divider models ----------------
  function automatic logic [63:0] div32(input logic s, input logic [31:0] n, input logic [31:0] d);
    if (d == 32'd0) return {32'hFFFF_FFFF, n};
    if (s) return {32'($signed(n) / $signed(d)), 32'($signed(n) % $signed(d))};
    return {n / d, n % d};
  endfunction

  function automatic logic [127:0] div64(input logic s, input logic [63:0] n, input logic [63:0] d);
    if (d == 64'd0) return {64'hFFFF_FFFF_FFFF_FFFF, n};
    if (s) return {64'($signed(n) / $signed(d)), 64'($signed(n) % $signed(d))};
    return {n / d, n % d};
  endfunction

  // 32-bit model: ready rises model_delay cycles after the enable cycle and
  // stays high until the next enable (stale ready as the real unit does).
  int   model_delay = 2;
  bit   model_never = 1'b0;
  logic m_active = 1'b0;
  int   m_cnt = 0;
  always @(posedge clk) begin
    if (div_enable) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
      if (model_delay == 1 && !model_never) begin
        div_data_ready     <= 1'b1;
        {div_quot, div_rem} <= div32(div_sgn, div_num, div_denom);
        m_active           <= 1'b0;
      end else begin
        div_data_ready <= 1'b0;
      end
    end else if (m_active) begin
      if (!model_never && m_cnt == model_delay - 1) begin
        div_data_ready     <= 1'b1;
        {div_quot, div_rem} <= div32(div_sgn, div_num, div_denom);
        m_active           <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // 64-bit model: fixed 3-cycle compute.
  logic w_active = 1'b0;
  int   w_cnt = 0;
  always @(posedge clk) begin
    if (w_div_enable) begin
      w_active         <= 1'b1;
      w_cnt            <= 1;
      w_div_data_ready <= 1'b0;
    end else if (w_active) begin
      if (w_cnt == 2) begin
        w_div_data_ready       <= 1'b1;
        {w_div_quot, w_div_rem} <= div64(w_div_sgn, w_div_num, w_div_denom);
        w_active               <= 1'b0;
      end else begin
        w_cnt <= w_cnt + 1;
      end
    end
  end

  // ---------------- bench infrastructure ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_count = 0;
  int en_cyc = 0;
  logic stale_at_en = 1'b0;
  int acc_cyc = 0;
  int rsp_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record enable pulses.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (div_enable) begin
      en_count++;
      en_cyc      = cyc;
      stale_at_en = div_data_ready;
    end
  endtask

  task automatic send32(input logic s, input logic [31:0] n, input logic [31:0] d);
    check("req_ready_before_accept", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_sgn = s; req_num = n; req_denom = d;
    step();
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp32(input int budget);
    int n;
    n = 0;
    while (!rsp_valid && n < budget) begin
      step();
      n++;
    end
    check("rsp_valid_within_budget", 64'(rsp_valid), 64'd1);
    rsp_cyc = cyc;
  endtask

  // Hold the response for two cycles, then take it.
  task automatic release32(input string name, input logic [31:0] exp_q);
    rsp_ready = 1'b0;
    step(); step();
    check({name, "_held_valid"}, 64'(rsp_valid), 64'd1);
    check({name, "_held_quot"}, 64'(rsp_quot), 64'(exp_q));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({name, "_valid_cleared"}, 64'(rsp_valid), 64'd0);
    check({name, "_flags_cleared"}, {62'd0, rsp_timeout, rsp_dbz}, 64'd0);
    check({name, "_req_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] num;
    logic [31:0] den;
    int          delay;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int en0;
    vecs[0] = '{"u100_7",    1'b0, 32'd100,         32'd7,           34, 32'd14,          32'd2};
    vecs[1] = '{"s-100_7",   1'b1, 32'hFFFF_FF9C,   32'd7,           34, 32'hFFFF_FFF2,   32'hFFFF_FFFE};
    vecs[2] = '{"u_max_16",  1'b0, 32'hFFFF_FFFF,   32'd16,          1,  32'h0FFF_FFFF,   32'hF};
    vecs[3] = '{"s7_-2",     1'b1, 32'd7,           32'hFFFF_FFFE,   5,  32'hFFFF_FFFD,   32'd1};
    vecs[4] = '{"ready_at_timeout", 1'b0, 32'd5,    32'd9,           TC32 - 1, 32'd0,     32'd5};

    rst = 1'b1;
    req_valid = 1'b0; req_sgn = 1'b0; req_num = '0; req_denom = '0;
    rsp_ready = 1'b0; div_can_accept_cmd = 1'b1;
    w_req_valid = 1'b0; w_req_sgn = 1'b0; w_req_num = '0; w_req_denom = '0; w_rsp_ready = 1'b0;
    step(); step();
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_outputs", {rsp_valid, rsp_timeout, rsp_dbz, div_enable, div_sgn, div_num, div_denom},
          64'd0);
    rst = 1'b0;
    step();
    check("post_reset_req_ready", 64'(req_ready), 64'd1);

    // Table-driven divides.
    foreach (vecs[i]) begin
      model_delay = vecs[i].delay;
      model_never = 1'b0;
      en0 = en_count;
      send32(vecs[i].sgn, vecs[i].num, vecs[i].den);
      check({vecs[i].name, "_issue_not_ready"}, 64'(req_ready), 64'd0);
      check({vecs[i].name, "_latched"}, {31'd0, div_sgn, div_num}, {31'd0, vecs[i].sgn, vecs[i].num});
      check({vecs[i].name, "_latched_den"}, 64'(div_denom), 64'(vecs[i].den));
      wait_rsp32(200);
      check({vecs[i].name, "_enable_cycle"}, 64'(en_cyc), 64'(acc_cyc + 1));
      check({vecs[i].name, "_latency"}, 64'(rsp_cyc), 64'(en_cyc + vecs[i].delay + 1));
      check({vecs[i].name, "_one_enable"}, 64'(en_count - en0), 64'd1);
      check({vecs[i].name, "_quot"}, 64'(rsp_quot), 64'(vecs[i].q));
      check({vecs[i].name, "_rem"}, 64'(rsp_rem), 64'(vecs[i].r));
      check({vecs[i].name, "_no_timeout"}, 64'(rsp_timeout), 64'd0);
      release32(vecs[i].name, vecs[i].q);
    end

    // Timeout with a stale ready high during the enable cycle.
    model_never = 1'b1;
    send32(1'b0, 32'd77, 32'd3);
    wait_rsp32(200);
    check("timeout_stale_ready_present", 64'(stale_at_en), 64'd1);
    check("timeout_latency", 64'(rsp_cyc), 64'(en_cyc + TC32));
    check("timeout_flag", 64'(rsp_timeout), 64'd1);
    check("timeout_results", {rsp_quot, rsp_rem}, 64'd0);
    release32("timeout", 32'd0);
    model_never = 1'b0;

    // Divider busy for 10 cycles after accept.
    model_delay = 4;
    div_can_accept_cmd = 1'b0;
    en0 = en_count;
    send32(1'b0, 32'd50, 32'd5);
    repeat (10) step();
    check("busy_no_enable", 64'(en_count - en0), 64'd0);
    check("busy_no_rsp", 64'(rsp_valid), 64'd0);
    div_can_accept_cmd = 1'b1;
    wait_rsp32(100);
    check("busy_one_enable", 64'(en_count - en0), 64'd1);
    check("busy_enable_cycle", 64'(en_cyc), 64'(acc_cyc + 11));
    check("busy_quot_rem", {rsp_quot, rsp_rem}, {32'd10, 32'd0});
    release32("busy", 32'd10);

    // Zero divisor.
    en0 = en_count;
    send32(1'b0, 32'h1234, 32'd0);
`ifdef DIVIDER_SEQUENCER_ZERO_CHECK_EN
    check("zero_rsp_at_t1", 64'(rsp_valid), 64'd1);
    check("zero_results", {rsp_quot, rsp_rem}, {32'hFFFF_FFFF, 32'h1234});
    check("zero_dbz", 64'(rsp_dbz), 64'd1);
    release32("zero", 32'hFFFF_FFFF);
    check("zero_no_enable", 64'(en_count - en0), 64'd0);
`else
    wait_rsp32(100);
    check("zero_enable_issued", 64'(en_count - en0), 64'd1);
    check("zero_dbz_tied_low", 64'(rsp_dbz), 64'd0);
    check("zero_results_from_divider", {rsp_quot, rsp_rem}, {32'hFFFF_FFFF, 32'h1234});
    release32("zero", 32'hFFFF_FFFF);
`endif

    // Reset while waiting on the divider, then a clean request.
    model_delay = 34;
    send32(1'b1, 32'd100, 32'd7);
    step(); step(); step();
    rst = 1'b1;
    step();
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_ctrl", {59'd0, rsp_valid, rsp_timeout, rsp_dbz, div_enable, div_sgn}, 64'd0);
    check("midrst_operands", {div_num, div_denom}, 64'd0);
    check("midrst_results", {rsp_quot, rsp_rem}, 64'd0);
    rst = 1'b0;
    step();
    send32(1'b0, 32'd200, 32'd9);
    wait_rsp32(200);
    check("after_rst_latency", 64'(rsp_cyc), 64'(en_cyc + 35));
    check("after_rst_quot_rem", {rsp_quot, rsp_rem}, {32'd22, 32'd2});
    release32("after_rst", 32'd22);

    // 64-bit: reset mid-wait, then two divides.
    check("w64_ready", 64'(w_req_ready), 64'd1);
    w_req_valid = 1'b1; w_req_sgn = 1'b1; w_req_num = 64'hFFFF_FFFF_FFFF_FC18; w_req_denom = 64'd3;
    step();
    w_req_valid = 1'b0;
    step(); step(); step();
    check("w64_in_flight", 64'(w_rsp_valid), 64'd0);
    rst = 1'b1;
    step();
    check("w64_midrst_ready", 64'(w_req_ready), 64'd1);
    check("w64_midrst_ctrl", {61'd0, w_rsp_valid, w_div_enable, w_div_sgn}, 64'd0);
    check("w64_midrst_num", w_div_num, 64'd0);
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      logic        s;
      logic [63:0] n, d, eq, er;
      int          t, budget;
      s  = (k == 1);
      n  = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FC18;
      d  = (k == 0) ? 64'h1_0000_0000 : 64'd3;
      eq = (k == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FEB3;
      er = (k == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      check("w64_req_ready", 64'(w_req_ready), 64'd1);
      w_req_valid = 1'b1; w_req_sgn = s; w_req_num = n; w_req_denom = d;
      step();
      w_req_valid = 1'b0;
      t = cyc;
      budget = 0;
      while (!w_rsp_valid && budget < 300) begin
        step();
        budget++;
      end
      check("w64_rsp_seen", 64'(w_rsp_valid), 64'd1);
      check("w64_latency", 64'(cyc), 64'(t + 5));
      check("w64_quot", w_rsp_quot, eq);
      check("w64_rem", w_rsp_rem, er);
      w_rsp_ready = 1'b1;
      step();
      w_rsp_ready = 1'b0;
      check("w64_valid_cleared", 64'(w_rsp_valid), 64'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
